// File: rtl/alu_addsub_seq_if.sv
// Start/done bus of the digit-serial add/subtract unit.
// cin and its modport entries exist only when ADDSUB_SEQ_CIN_EN is defined.
interface alu_addsub_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic             logical;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef ADDSUB_SEQ_CIN_EN
  logic             cin;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             of;
  logic             sf;
  logic             zf;

`ifdef ADDSUB_SEQ_CIN_EN
  modport master (output start, sub, logical, a, b, cin, input busy, done, s, of, sf, zf);
  modport slave  (input start, sub, logical, a, b, cin, output busy, done, s, of, sf, zf);
`else
  modport master (output start, sub, logical, a, b, input busy, done, s, of, sf, zf);
  modport slave  (input start, sub, logical, a, b, output busy, done, s, of, sf, zf);
`endif
endinterface

// File: rtl/alu_addsub_seq.sv
// Digit-serial add/subtract with COMET2 OF/SF/ZF flags, DIGIT bits per cycle, LSB slice first.
// Optional ADDSUB_SEQ_CIN_EN adds a latched carry/borrow-in for multi-word chaining.
module alu_addsub_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic            clk,
  input logic            rst,
  alu_addsub_seq_if.slave bus
);
  localparam int N     = WIDTH / DIGIT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] s_r;
  logic [IDX_W-1:0] idx_r;
  logic             sub_r;
  logic             logical_r;
  logic             carry_r;
  logic             busy_r;
  logic             done_r;
  logic             of_r;
  logic             sf_r;
  logic             zf_r;

  logic [DIGIT-1:0] bx_s;
  logic [DIGIT:0]   sum_s;
  logic [WIDTH-1:0] res_next_s;
  logic             carry_in_s;
  logic             msb_cin_s;
  logic             of_s;

  // Slice adder, shifted-in result and flag candidates for the final slice
  always_comb begin
`ifdef ADDSUB_SEQ_CIN_EN
    carry_in_s = bus.sub ? ~bus.cin : bus.cin;
`else
    carry_in_s = bus.sub;
`endif
    bx_s       = b_r[DIGIT-1:0] ^ {DIGIT{sub_r}};
    sum_s      = {1'b0, a_r[DIGIT-1:0]} + {1'b0, bx_s} + {{DIGIT{1'b0}}, carry_r};
    res_next_s = (res_r >> DIGIT) | (WIDTH'(sum_s[DIGIT-1:0]) << (WIDTH - DIGIT));
    // carry into the MSB is recovered from the MSB's own sum bit
    msb_cin_s  = a_r[DIGIT-1] ^ bx_s[DIGIT-1] ^ sum_s[DIGIT-1];
    if (!logical_r) begin
      of_s = msb_cin_s ^ sum_s[DIGIT];
    end else if (sub_r) begin
      of_s = ~sum_s[DIGIT];
    end else begin
      of_s = sum_s[DIGIT];
    end
  end

  // Control FSM, operand/result shift registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      res_r     <= '0;
      s_r       <= '0;
      idx_r     <= '0;
      sub_r     <= 1'b0;
      logical_r <= 1'b0;
      carry_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      of_r      <= 1'b0;
      sf_r      <= 1'b0;
      zf_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (bus.start) begin
            a_r       <= bus.a;
            b_r       <= bus.b;
            sub_r     <= bus.sub;
            logical_r <= bus.logical;
            carry_r   <= carry_in_s;
            idx_r     <= '0;
            busy_r    <= 1'b1;
            state_r   <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          res_r   <= res_next_s;
          carry_r <= sum_s[DIGIT];
          idx_r   <= idx_r + IDX_W'(1);
          if (idx_r == IDX_W'(N - 1)) begin
            s_r     <= res_next_s;
            of_r    <= of_s;
            sf_r    <= res_next_s[WIDTH-1];
            zf_r    <= (res_next_s == '0);
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.s    = s_r;
  assign bus.of   = of_r;
  assign bus.sf   = sf_r;
  assign bus.zf   = zf_r;
endmodule

// File: tb/tb_alu_addsub_seq.sv
// Bench for alu_addsub_seq: a 16/4 instance and an 8/8 (single-slice) instance,
// table vectors, handshake/reset sequences, and random ops against an arithmetic model.
module tb_alu_addsub_seq;
  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  logic [15:0] prev_s16 = 16'h0000;
  logic        cin_v = 1'b0;

`ifdef ADDSUB_SEQ_CIN_EN
  localparam bit CIN_EN = 1'b1;
`else
  localparam bit CIN_EN = 1'b0;
`endif

  alu_addsub_seq_if #(.WIDTH(16)) b16 ();
  alu_addsub_seq_if #(.WIDTH(8))  b8 ();

  alu_addsub_seq #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  alu_addsub_seq #(.WIDTH(8),  .DIGIT(8)) dut8  (.clk(clk), .rst(rst), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        logical;
    logic [15:0] s;
    logic        of;
    logic        sf;
    logic        zf;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on w-bit operands
  function automatic void model(input int w, input longint unsigned a, input longint unsigned b,
                                input bit sub, input bit logical, input bit cin,
                                output longint unsigned s, output bit of, output bit sf, output bit zf);
    longint m    = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint ci   = (CIN_EN && cin) ? 1 : 0;
    longint sa   = (longint'(a) >= half) ? longint'(a) - (m + 1) : longint'(a);
    longint sb   = (longint'(b) >= half) ? longint'(b) - (m + 1) : longint'(b);
    longint rs   = sub ? sa - sb - ci : sa + sb + ci;
    longint ru   = sub ? longint'(a) - longint'(b) - ci : longint'(a) + longint'(b) + ci;
    if (!logical) of = (rs < -half) || (rs >= half);
    else if (sub) of = (ru < 0);
    else          of = (ru > m);
    s  = longint'(ru & m);
    sf = ((s >> (w - 1)) & 1) != 0;
    zf = (s == 0);
  endfunction

  // Count negedges until done (bounded); flag busy drop or s change before done
  task automatic wait_done16(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!b16.done && (!b16.busy || b16.s !== prev_s16)) ok = 1'b0;
    end while (!b16.done && lat < 20);
  endtask

  task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic logical);
    b16.start = 1'b1; b16.a = a; b16.b = b; b16.sub = sub; b16.logical = logical;
`ifdef ADDSUB_SEQ_CIN_EN
    b16.cin = cin_v;
`endif
    @(posedge clk);
    #1;
    b16.start = 1'b0; b16.a = 16'($urandom); b16.b = 16'($urandom);
    b16.sub = 1'($urandom); b16.logical = 1'($urandom);
`ifdef ADDSUB_SEQ_CIN_EN
    b16.cin = 1'($urandom);
`endif
  endtask

  task automatic run16(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic logical,
                       input logic [15:0] es, input logic eof, input logic esf, input logic ezf);
    int lat;
    bit ok;
    @(negedge clk);
    drive16(a, b, sub, logical);
    wait_done16(lat, ok);
    check({name, ".latency"}, lat, 5);
    check({name, ".busy_hold"}, ok, 1);
    check({name, ".s"}, b16.s, es);
    check({name, ".of"}, b16.of, eof);
    check({name, ".sf"}, b16.sf, esf);
    check({name, ".zf"}, b16.zf, ezf);
    prev_s16 = es;
    @(negedge clk);
    check({name, ".pulse"}, {b16.done, b16.busy, b16.s}, {2'b00, es});
  endtask

  task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic sub, input logic logical);
    int lat = 0;
    longint unsigned es;
    bit eof, esf, ezf;
    model(8, a, b, sub, logical, cin_v, es, eof, esf, ezf);
    @(negedge clk);
    b8.start = 1'b1; b8.a = a; b8.b = b; b8.sub = sub; b8.logical = logical;
`ifdef ADDSUB_SEQ_CIN_EN
    b8.cin = cin_v;
`endif
    @(posedge clk);
    #1;
    b8.start = 1'b0; b8.a = 8'($urandom); b8.b = 8'($urandom);
    do begin
      @(negedge clk);
      lat++;
    end while (!b8.done && lat < 20);
    check({name, ".latency"}, lat, 2);
    check({name, ".result"}, {b8.s, b8.of, b8.sf, b8.zf}, {es[7:0], eof, esf, ezf});
  endtask

  initial begin
    longint unsigned es;
    bit eof, esf, ezf;
    int lat;
    bit ok;
    bit extra;
    logic [15:0] ra, rb;
    logic rsub, rlog;

    b16.start = 1'b0; b16.a = '0; b16.b = '0; b16.sub = 1'b0; b16.logical = 1'b0;
    b8.start  = 1'b0; b8.a  = '0; b8.b  = '0; b8.sub  = 1'b0; b8.logical  = 1'b0;
`ifdef ADDSUB_SEQ_CIN_EN
    b16.cin = 1'b0;
    b8.cin  = 1'b0;
`endif
    tbl[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset16", {b16.busy, b16.done, b16.s, b16.of, b16.sf, b16.zf}, 21'd0);
    check("reset8", {b8.busy, b8.done, b8.s, b8.of, b8.sf, b8.zf}, 13'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run16($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].logical,
            tbl[i].s, tbl[i].of, tbl[i].sf, tbl[i].zf);
    end

    // start while busy is ignored
    @(negedge clk);
    drive16(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    b16.start = 1'b1; b16.a = 16'hFFFF; b16.b = 16'hFFFF; b16.sub = 1'b1;
    @(posedge clk);
    #1;
    b16.start = 1'b0;
    wait_done16(lat, ok);
    check("ignore.latency", lat, 3);
    check("ignore.s", b16.s, 16'h3333);
    prev_s16 = 16'h3333;
    extra = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (b16.done || b16.busy) extra = 1'b1;
    end
    check("ignore.no_second_op", extra, 1'b0);

    // back-to-back: start in the done cycle
    @(negedge clk);
    drive16(16'h0100, 16'h0023, 1'b0, 1'b0);
    wait_done16(lat, ok);
    check("b2b.first_latency", lat, 5);
    check("b2b.first_s", b16.s, 16'h0123);
    prev_s16 = 16'h0123;
    drive16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done16(lat, ok);
    check("b2b.second_latency", lat, 5);
    check("b2b.second_result", {b16.s, b16.of, b16.sf, b16.zf}, {16'h8000, 3'b110});
    prev_s16 = 16'h8000;

    // reset mid-RUN abandons the op
    @(negedge clk);
    @(negedge clk);
    drive16(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst.state", {b16.busy, b16.done, b16.s, b16.of, b16.sf, b16.zf}, 21'd0);
    extra = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (b16.done || b16.busy) extra = 1'b1;
    end
    check("midrst.no_done", extra, 1'b0);
    prev_s16 = 16'h0000;
    run16("after_rst", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0);

`ifdef ADDSUB_SEQ_CIN_EN
    cin_v = 1'b1;
    run16("cin_add", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
    run16("cin_sub", 16'h0005, 16'h0002, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    cin_v = 1'b0;
`endif

    for (int i = 0; i < 40; i++) begin
      ra   = 16'($urandom);
      rb   = (i % 5 == 0) ? ra : 16'($urandom);
      rsub = 1'($urandom);
      rlog = 1'($urandom);
      cin_v = 1'($urandom);
      model(16, ra, rb, rsub, rlog, cin_v, es, eof, esf, ezf);
      run16($sformatf("rnd%0d", i), ra, rb, rsub, rlog, es[15:0], eof, esf, ezf);
    end

    cin_v = 1'b0;
    run8("n1_spec", 8'h7F, 8'h01, 1'b0, 1'b0);
    check("n1_spec.of", b8.of, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cin_v = 1'($urandom);
      run8($sformatf("n1_rnd%0d", i), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_addsub_seq.md
# alu_addsub_seq

Parametrised, digit-serial add/subtract unit for the COMET2 ALU. It is the multi-cycle successor to the fixed 4-bit ripple adder. Each cycle it pushes one DIGIT-bit slice of a WIDTH-bit operand pair through a ripple stage and keeps the carry between slices. When the operation finishes it outputs the result together with the COMET2 flags (OF, SF, ZF). It serves ADDA/ADDL/SUBA/SUBL and the address adder, and sits behind the execute-stage start/done handshake.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of DIGIT
- DIGIT, 4, bits processed per cycle; N = WIDTH/DIGIT slices

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous and active-high
- start  in  1  request; sampled only when busy=0
- sub  in  1  1 = a − b, 0 = a + b; captured on accept
- logical  in  1  1 = logical (ADDL/SUBL) flags, 0 = arithmetic; captured on accept
- a  in  WIDTH  operand A; captured on accept
- b  in  WIDTH  operand B; captured on accept
- cin  in  1  carry/borrow in; present only with ADDSUB_SEQ_CIN_EN
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; result and flags valid
- s  out  WIDTH  result; held until the next done
- of  out  1  overflow flag
- sf  out  1  sign flag (s[WIDTH-1])
- zf  out  1  zero flag (s == 0)

## Operation
- States:
  - IDLE: start=1 → accept. Latch a, b, sub, logical. Set slice index i=0. Set the carry register to the carry-in (see below). Go to RUN.
  - RUN: each cycle, slice i computes a_slice + (b_slice XOR {DIGIT{sub}}) + carry. Write the sum into the result shift register and update the carry. Increment i. After slice N−1, go to DONE.
  - DONE: for one cycle, drive s, of, sf, zf and assert done=1. Go to IDLE.
- Carry-in:
  - sub=0: carry-in is 0.
  - sub=1: carry-in is 1 (two's complement).
- Flags, computed from the final slice:
  - logical=0: of = carry into MSB XOR carry out of MSB (signed overflow).
  - logical=1, sub=0: of = carry out.
  - logical=1, sub=1: of = NOT carry out (borrow).
  - sf = s[WIDTH-1]; zf = (s == 0).
- Output updates: s and flags change only in the DONE cycle. RUN-cycle intermediates are never visible on s.
- Arithmetic is modulo 2^WIDTH; there is no saturation.

## Timing
- Latency: start accepted at edge k. busy=1 for cycles k+1 .. k+N. done=1 in cycle k+N+1 only; busy=0 in that cycle.
- Result and flags are registered. They are valid from the done cycle and held until the next done.
- start while busy=1 is ignored, and the operands are not re-latched.
- start in the done cycle is accepted, giving back-to-back operations every N+1 cycles.
- Operand inputs may change freely after accept.
- Reset values:
  - state IDLE, busy=0, done=0
  - s=0, of=0, sf=0, zf=0
  - internal carry and index cleared
- Reset during RUN or DONE abandons the operation. The following cycle shows the reset values, and no done pulse is produced.
- rst has priority over start in the same cycle.
- WIDTH==DIGIT (N=1): one RUN cycle, so done appears at k+2.

## Configuration
- ADDSUB_SEQ_CIN_EN defined: port cin exists, enabling multi-word ADC/SBC chaining.
  - Carry-in = cin for add; carry-in = NOT cin for subtract (cin acts as borrow-in).
  - cin is latched on accept.
- Undefined: no cin port; carry-in is 0 for add and 1 for subtract.
- The flag rules are identical in both builds.

## Test plan
All scenarios use WIDTH=16, DIGIT=4.
- Arithmetic add, a=0x7FFF, b=0x0001 → done at k+5, s=0x8000, of=1, sf=1, zf=0.
- Logical add, a=0xFFFF, b=0x0001 → s=0x0000, of=1, sf=0, zf=1.
- Logical sub, a=0x0003, b=0x0005 → s=0xFFFE, of=1 (borrow), sf=1. Arithmetic sub, a=0x8000, b=0x0001 → s=0x7FFF, of=1, sf=0.
- Handshake:
  - Pulse start with new operands at k+2 (busy): ignored, first result unchanged.
  - start in the done cycle: accepted, second done exactly 5 cycles later.
- Reset:
  - Assert rst at k+3 mid-RUN → next cycle busy=0, s=0, flags 0, and no done for that operation.
  - A new start afterwards completes normally.
- With ADDSUB_SEQ_CIN_EN:
  - a=0x0001, b=0x0001, cin=1 add → s=0x0003.
  - a=0x0005, b=0x0002, cin=1 sub → s=0x0002.
- N=1 build (WIDTH=DIGIT=8): a=0x7F + b=0x01 arithmetic → done at k+2, s=0x80, of=1.
